fetch_memory_interface: RTL and testbench

FETCH_MEMORY_INTERFACE -- requirements
Module: fetch_memory_interface

---
 rtl/fetch_memory_interface_if.sv | 24 ++
 rtl/fetch_memory_interface.sv | 189 ++++++++++++++++++
 tb/tb_fetch_memory_interface.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_memory_interface_if.sv
// Instruction-memory read bus: the fetch interface is the master, the memory is the slave.
interface fetch_memory_interface_if;
    logic [31:0] memAddress;
    logic        memRequest;
    logic [31:0] memReadData;
    logic        memAck;
    logic        memError;

    modport master (
        output memAddress,
        output memRequest,
        input  memReadData,
        input  memAck,
        input  memError
    );

    modport slave (
        input  memAddress,
        input  memRequest,
        output memReadData,
        output memAck,
        output memError
    );
endinterface

// File: rtl/fetch_memory_interface.sv
// Single-word instruction fetch buffer with request timeout and stale-request discard.
// Optional macro FETCH_PREFETCH_EN adds a sequential next-word prefetch buffer.
module fetch_memory_interface #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [31:0]                     fetchAddress,
    input  logic                            fetchEnable,
    output logic [31:0]                     currentInstruction,
    output logic                            fetchBusy,
    output logic                            fetchError,
    fetch_memory_interface_if.master        mem
);
    typedef enum logic [1:0] {IDLE, WAIT, DISCARD, VALID} state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] buffer_q, buffer_d;
    logic [29:0] tag_q, tag_d;
    logic        err_q, err_d;
    logic [7:0]  count_q, count_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;

    logic [29:0] fetch_tag;
    logic [7:0]  count_inc;
    logic        hit;
    logic        timeout;
    logic        unused_addr_bits;

`ifdef FETCH_PREFETCH_EN
    logic [31:0] pf_data_q, pf_data_d;
    logic [29:0] pf_tag_q, pf_tag_d;
    logic        pf_valid_q, pf_valid_d;
    logic        pf_pend_q, pf_pend_d;
    logic        pf_done;
`endif

    assign fetch_tag          = fetchAddress[31:2];
    assign unused_addr_bits   = ^fetchAddress[1:0];
    assign hit                = (state_q == VALID) && (tag_q == fetch_tag);
    assign fetchBusy          = fetchEnable && !hit;
    assign currentInstruction = hit ? buffer_q : 32'hFFFF_FFFF;
    assign fetchError         = hit && err_q;
    assign mem.memRequest     = mem_req_q;
    assign mem.memAddress     = mem_addr_q;
    assign count_inc          = count_q + 8'd1;
    assign timeout            = (count_inc >= TIMEOUT_LIMIT);

`ifdef FETCH_PREFETCH_EN
    assign pf_done = pf_pend_q && (mem.memAck || mem.memError || timeout);
`endif

    // Next-state logic; timeout is checked before the stale-address test so a
    // request that is abandoned on its last allowed cycle never outlives the limit.
    always_comb begin
        state_d    = state_q;
        buffer_d   = buffer_q;
        tag_d      = tag_q;
        err_d      = err_q;
        count_d    = count_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
`ifdef FETCH_PREFETCH_EN
        pf_data_d  = pf_data_q;
        pf_tag_d   = pf_tag_q;
        pf_valid_d = pf_valid_q;
        pf_pend_d  = pf_pend_q;
`endif
        unique case (state_q)
            IDLE, VALID: begin
`ifdef FETCH_PREFETCH_EN
                if (pf_pend_q) begin
                    count_d = count_inc;
                    if (mem.memError || timeout) begin
                        pf_pend_d = 1'b0;
                        mem_req_d = 1'b0;
                    end else if (mem.memAck) begin
                        pf_pend_d  = 1'b0;
                        mem_req_d  = 1'b0;
                        pf_valid_d = 1'b1;
                        pf_data_d  = mem.memReadData;
                    end
                end
                if (fetchEnable && !hit) begin
                    if (pf_valid_q && (pf_tag_q == fetch_tag)) begin
                        buffer_d   = pf_data_q;
                        tag_d      = pf_tag_q;
                        err_d      = 1'b0;
                        state_d    = VALID;
                        pf_tag_d   = pf_tag_q + 30'd1;
                        pf_pend_d  = 1'b1;
                        pf_valid_d = 1'b0;
                        count_d    = 8'd0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {pf_tag_q + 30'd1, 2'b00};
                    end else if (pf_pend_q && !pf_done && (pf_tag_q == fetch_tag)) begin
                        tag_d     = pf_tag_q;
                        pf_pend_d = 1'b0;
                        state_d   = WAIT;
                    end else if (pf_pend_q && !pf_done) begin
                        pf_pend_d = 1'b0;
                        state_d   = DISCARD;
                    end else begin
                        tag_d      = fetch_tag;
                        count_d    = 8'd0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {fetch_tag, 2'b00};
                        state_d    = WAIT;
                    end
                end
`else
                if (fetchEnable && !hit) begin
                    tag_d      = fetch_tag;
                    count_d    = 8'd0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {fetch_tag, 2'b00};
                    state_d    = WAIT;
                end
`endif
            end
            WAIT: begin
                count_d = count_inc;
                if (mem.memError || (!mem.memAck && timeout)) begin
                    buffer_d  = 32'hFFFF_FFFF;
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = VALID;
                end else if (mem.memAck) begin
                    buffer_d  = mem.memReadData;
                    err_d     = 1'b0;
                    mem_req_d = 1'b0;
                    state_d   = VALID;
`ifdef FETCH_PREFETCH_EN
                    pf_tag_d   = tag_q + 30'd1;
                    pf_pend_d  = 1'b1;
                    pf_valid_d = 1'b0;
                    count_d    = 8'd0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {tag_q + 30'd1, 2'b00};
`endif
                end else if (!fetchEnable || (fetch_tag != tag_q)) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                count_d = count_inc;
                if (mem.memAck || mem.memError || timeout) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            buffer_q   <= 32'hFFFF_FFFF;
            tag_q      <= '0;
            err_q      <= 1'b0;
            count_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
`ifdef FETCH_PREFETCH_EN
            pf_data_q  <= 32'hFFFF_FFFF;
            pf_tag_q   <= '0;
            pf_valid_q <= 1'b0;
            pf_pend_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            buffer_q   <= buffer_d;
            tag_q      <= tag_d;
            err_q      <= err_d;
            count_q    <= count_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
`ifdef FETCH_PREFETCH_EN
            pf_data_q  <= pf_data_d;
            pf_tag_q   <= pf_tag_d;
            pf_valid_q <= pf_valid_d;
            pf_pend_q  <= pf_pend_d;
`endif
        end
    end
endmodule

// File: tb/tb_fetch_memory_interface.sv
// Self-checking bench for fetch_memory_interface: vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_fetch_memory_interface;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] fetchAddress = '0;
    logic        fetchEnable = 1'b0;
    logic [31:0] currentInstruction;
    logic        fetchBusy;
    logic        fetchError;

    fetch_memory_interface_if memBus();

    fetch_memory_interface #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk                (clk),
        .rst                (rst),
        .fetchAddress       (fetchAddress),
        .fetchEnable        (fetchEnable),
        .currentInstruction (currentInstruction),
        .fetchBusy          (fetchBusy),
        .fetchError         (fetchError),
        .mem                (memBus.master)
    );

    always #5 clk = ~clk;

    int checksDone   = 0;
    int checksPassed = 0;

    typedef struct {
        logic        fe;
        logic [31:0] fa;
        logic        ack;
        logic        err;
        logic [31:0] rdata;
        logic        expBusy;
        logic        expReq;
        logic [31:0] expAddr;
        logic [31:0] expInstr;
        logic        expErr;
    } vector_t;

    vector_t vectors[13];

    // Reference model: one outstanding read (live or abandoned) plus one held word.
    logic        mPending, mLive, mHeld, mHeldErr;
    logic [29:0] mTag, mHeldTag;
    logic [31:0] mHeldData;
    int          mAge;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checksDone++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        else
            checksPassed++;
    endtask

    task automatic applyStimulus(input logic fe, input logic [31:0] fa, input logic ack,
                                 input logic err, input logic [31:0] rdata);
        @(negedge clk);
        fetchEnable        = fe;
        fetchAddress       = fa;
        memBus.memAck      = ack;
        memBus.memError    = err;
        memBus.memReadData = rdata;
        #1;
    endtask

    task automatic doReset(input logic doChecks);
        @(negedge clk);
        rst                = 1'b0;
        fetchEnable        = 1'b1;
        fetchAddress       = 32'h0;
        memBus.memAck      = 1'b0;
        memBus.memError    = 1'b0;
        memBus.memReadData = 32'h0;
        #1;
        if (doChecks) begin
            checkOutput("reset-req",   32'(memBus.memRequest), 32'h0);
            checkOutput("reset-addr",  memBus.memAddress,      32'h0);
            checkOutput("reset-busy",  32'(fetchBusy),         32'h1);
            checkOutput("reset-ferr",  32'(fetchError),        32'h0);
            checkOutput("reset-instr", currentInstruction,     32'hFFFF_FFFF);
        end
        @(negedge clk);
        fetchEnable = 1'b0;
        rst         = 1'b1;
        mPending = 1'b0; mLive = 1'b0; mHeld = 1'b0; mHeldErr = 1'b0;
        mTag = '0; mHeldTag = '0; mHeldData = 32'hFFFF_FFFF; mAge = 0;
    endtask

    task automatic modelStep(input logic fe, input logic [31:0] fa, input logic ack,
                             input logic err, input logic [31:0] rdata);
        logic hitNow;
        hitNow = mHeld && !mPending && (mHeldTag == fa[31:2]);
        if (mPending) begin
            mAge++;
            if (mLive) begin
                if (err || (!ack && mAge >= TIMEOUT)) begin
                    mPending = 1'b0; mHeld = 1'b1; mHeldTag = mTag;
                    mHeldData = 32'hFFFF_FFFF; mHeldErr = 1'b1;
                end else if (ack) begin
                    mPending = 1'b0; mHeld = 1'b1; mHeldTag = mTag;
                    mHeldData = rdata; mHeldErr = 1'b0;
                end else if (!fe || (fa[31:2] != mTag)) begin
                    mLive = 1'b0;
                end
            end else if (ack || err || mAge >= TIMEOUT) begin
                mPending = 1'b0;
            end
        end else if (fe && !hitNow) begin
            mPending = 1'b1; mLive = 1'b1; mTag = fa[31:2]; mAge = 0; mHeld = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] addrPool [4];
        logic        rFe, rAck, rErr, expHit;
        logic [31:0] rFa, rData;
        int          reqCycles;
        logic        seenDrop;
        logic        sawStale;

        addrPool[0] = 32'h100; addrPool[1] = 32'h104; addrPool[2] = 32'h200; addrPool[3] = 32'h7FFC;
        memBus.memAck = 1'b0; memBus.memError = 1'b0; memBus.memReadData = '0;

        doReset(1'b1);

`ifdef FETCH_PREFETCH_EN
        applyStimulus(1, 32'h100, 0, 0, 0);
        applyStimulus(1, 32'h100, 0, 0, 0);
        checkOutput("pf-first-addr", memBus.memAddress, 32'h100);
        applyStimulus(1, 32'h100, 1, 0, 32'hAAAA_0001);
        applyStimulus(1, 32'h100, 0, 0, 0);
        checkOutput("pf-first-busy",  32'(fetchBusy),         32'h0);
        checkOutput("pf-first-instr", currentInstruction,     32'hAAAA_0001);
        checkOutput("pf-spec-req",    32'(memBus.memRequest), 32'h1);
        checkOutput("pf-spec-addr",   memBus.memAddress,      32'h104);
        applyStimulus(1, 32'h100, 1, 0, 32'hBBBB_0002);
        applyStimulus(1, 32'h104, 0, 0, 0);
        checkOutput("pf-promote-busy0", 32'(fetchBusy), 32'h1);
        applyStimulus(1, 32'h104, 0, 0, 0);
        checkOutput("pf-promote-busy1", 32'(fetchBusy),     32'h0);
        checkOutput("pf-promote-instr", currentInstruction, 32'hBBBB_0002);
        checkOutput("pf-promote-ferr",  32'(fetchError),    32'h0);
`else
        // Vector table: request/ack latency, low-bit aliasing, error strobe, error-over-ack.
        vectors[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,   32'hFFFF_FFFF, 1'b0};
        vectors[1]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100, 32'hFFFF_FFFF, 1'b0};
        vectors[2]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100, 32'hFFFF_FFFF, 1'b0};
        vectors[3]  = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h00500093, 1'b1, 1'b1, 32'h100, 32'hFFFF_FFFF, 1'b0};
        vectors[4]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h00500093,  1'b0};
        vectors[5]  = '{1'b0, 32'h100, 1'b1, 1'b0, 32'h5555_5555, 1'b0, 1'b0, 32'h0,  32'h00500093,  1'b0};
        vectors[6]  = '{1'b1, 32'h103, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h00500093,  1'b0};
        vectors[7]  = '{1'b1, 32'h400, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,   32'hFFFF_FFFF, 1'b0};
        vectors[8]  = '{1'b1, 32'h400, 1'b0, 1'b1, 32'h0,        1'b1, 1'b1, 32'h400, 32'hFFFF_FFFF, 1'b0};
        vectors[9]  = '{1'b1, 32'h400, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'hFFFF_FFFF, 1'b1};
        vectors[10] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,   32'hFFFF_FFFF, 1'b0};
        vectors[11] = '{1'b1, 32'h100, 1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'h100, 32'hFFFF_FFFF, 1'b0};
        vectors[12] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'hFFFF_FFFF, 1'b1};

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vectors[i].fe, vectors[i].fa, vectors[i].ack, vectors[i].err, vectors[i].rdata);
            checkOutput($sformatf("vec%0d-busy", i),  32'(fetchBusy),         32'(vectors[i].expBusy));
            checkOutput($sformatf("vec%0d-req", i),   32'(memBus.memRequest), 32'(vectors[i].expReq));
            checkOutput($sformatf("vec%0d-instr", i), currentInstruction,     vectors[i].expInstr);
            checkOutput($sformatf("vec%0d-ferr", i),  32'(fetchError),        32'(vectors[i].expErr));
            if (vectors[i].expReq)
                checkOutput($sformatf("vec%0d-addr", i), memBus.memAddress, vectors[i].expAddr);
        end

        // Address change mid-request: stale word must never be delivered.
        doReset(1'b0);
        sawStale = 1'b0;
        applyStimulus(1, 32'h200, 0, 0, 0);
        applyStimulus(1, 32'h300, 0, 0, 0);
        checkOutput("disc-wait-addr", memBus.memAddress, 32'h200);
        applyStimulus(1, 32'h300, 1, 0, 32'h1111_1111);
        checkOutput("disc-held-req",  32'(memBus.memRequest), 32'h1);
        checkOutput("disc-held-addr", memBus.memAddress,      32'h200);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 32'h300, (i == 2), 0, (i == 2) ? 32'h2222_2222 : 32'h1111_1111);
            if (currentInstruction == 32'h1111_1111) sawStale = 1'b1;
            if (i == 0) checkOutput("disc-idle-req", 32'(memBus.memRequest), 32'h0);
            if (i == 1) checkOutput("disc-new-addr", memBus.memAddress,      32'h300);
        end
        checkOutput("disc-new-instr", currentInstruction, 32'h2222_2222);
        checkOutput("disc-new-busy",  32'(fetchBusy),     32'h0);
        checkOutput("disc-no-stale",  32'(sawStale),      32'h0);

        // Timeout with no response at all.
        doReset(1'b0);
        applyStimulus(1, 32'h500, 0, 0, 0);
        reqCycles = 0;
        seenDrop  = 1'b0;
        for (int i = 0; i < 20 && !seenDrop; i++) begin
            applyStimulus(1, 32'h500, 0, 0, 0);
            if (memBus.memRequest) reqCycles++;
            else seenDrop = 1'b1;
        end
        checkOutput("tmo-req-cycles", 32'(reqCycles),     32'(TIMEOUT));
        checkOutput("tmo-dropped",    32'(seenDrop),      32'h1);
        checkOutput("tmo-ferr",       32'(fetchError),    32'h1);
        checkOutput("tmo-busy",       32'(fetchBusy),     32'h0);
        checkOutput("tmo-instr",      currentInstruction, 32'hFFFF_FFFF);

        // Asynchronous reset in the middle of a request, then a late ack.
        doReset(1'b0);
        applyStimulus(1, 32'h0, 0, 0, 0);
        applyStimulus(1, 32'h0, 0, 0, 0);
        checkOutput("rstw-req-before", 32'(memBus.memRequest), 32'h1);
        #2 rst = 1'b0;
        #1;
        checkOutput("rstw-req",  32'(memBus.memRequest), 32'h0);
        checkOutput("rstw-addr", memBus.memAddress,      32'h0);
        checkOutput("rstw-busy", 32'(fetchBusy),         32'(fetchEnable));
        checkOutput("rstw-ferr", 32'(fetchError),        32'h0);
        @(negedge clk);
        rst = 1'b1;
        fetchEnable = 1'b0;
        applyStimulus(0, 32'h0, 1, 0, 32'hDEAD_BEEF);
        checkOutput("rstw-ack-req", 32'(memBus.memRequest), 32'h0);
        applyStimulus(0, 32'h0, 0, 0, 0);
        checkOutput("rstw-ignored-instr", currentInstruction, 32'hFFFF_FFFF);
        applyStimulus(1, 32'h0, 0, 0, 0);
        checkOutput("rstw-idle-busy", 32'(fetchBusy),         32'h1);
        checkOutput("rstw-idle-req",  32'(memBus.memRequest), 32'h0);
        applyStimulus(1, 32'h0, 0, 0, 0);
        checkOutput("rstw-new-req",   32'(memBus.memRequest), 32'h1);

        // Randomized traffic against the reference model.
        doReset(1'b0);
        rFa = addrPool[0];
        for (int cyc = 0; cyc < 600; cyc++) begin
            rFe = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 3)
                rFa = addrPool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
            rAck  = ($urandom_range(0, 2) == 0);
            rErr  = ($urandom_range(0, 9) == 0);
            rData = $urandom;
            applyStimulus(rFe, rFa, rAck, rErr, rData);
            expHit = mHeld && !mPending && (mHeldTag == rFa[31:2]);
            checkOutput("rnd-busy",  32'(fetchBusy),         32'(rFe && !expHit));
            checkOutput("rnd-req",   32'(memBus.memRequest), 32'(mPending));
            checkOutput("rnd-instr", currentInstruction,     expHit ? mHeldData : 32'hFFFF_FFFF);
            checkOutput("rnd-ferr",  32'(fetchError),        32'(expHit && mHeldErr));
            if (mPending)
                checkOutput("rnd-addr", memBus.memAddress, {mTag, 2'b00});
            modelStep(rFe, rFa, rAck, rErr, rData);
        end
`endif

        $display("%0d/%0d checks passed", checksPassed, checksDone);
        $finish;
    end
endmodule
